// File: rtl/pg_adder_pkg.sv
// pg_adder_pkg: shared width default, level count helper and stage record for the prefix adder
package pg_adder_pkg;
  localparam int PG_WIDTH = 32;
  function automatic int levels_of(input int width);
    return $clog2(width);
  endfunction
  typedef struct packed {
    logic [PG_WIDTH-1:0] p;
    logic [PG_WIDTH-1:0] g;
    logic [PG_WIDTH-1:0] praw;
    logic                cin;
    logic                valid;
  } pg_stage_t;
endpackage

// File: rtl/pg_dot.sv
// pg_dot: one Kogge-Stone prefix cell combining a high and a low (G,P) pair
module pg_dot (
  input  logic gh,
  input  logic ph,
  input  logic gl,
  input  logic pl,
  output logic g,
  output logic p
);
  assign g = gh | (ph & gl);
  assign p = ph & pl;
endmodule

// File: rtl/pg_prefix_adder_pipe.sv
// pg_prefix_adder_pipe: pipelined Kogge-Stone adder with valid/ready; PG_ADDER_SUB_EN adds a subtract input
module pg_prefix_adder_pipe
  import pg_adder_pkg::*;
#(
  parameter int WIDTH = PG_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef PG_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int LEVELS = levels_of(WIDTH);
  typedef struct packed {
    logic [WIDTH-1:0] p;
    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] praw;
    logic             cin;
    logic             valid;
  } stage_t;
  stage_t st [0:LEVELS];
  stage_t nx [0:LEVELS];
  logic en;
  logic c_eff;
  logic [WIDTH-1:0] b_eff, p0, g0, carry;
  // a stalled output freezes every stage at once
  assign en = ~(out_valid & ~out_ready);
  assign in_ready = en;
`ifdef PG_ADDER_SUB_EN
  assign b_eff = b ^ {WIDTH{sub}};
  assign c_eff = cin ^ sub;
`else
  assign b_eff = b;
  assign c_eff = cin;
`endif
  // carry-in is folded into bit 0 so the prefix tree yields carries directly
  assign p0 = a ^ b_eff;
  assign g0 = (a & b_eff) | {{(WIDTH-1){1'b0}}, p0[0] & c_eff};
  assign nx[0] = '{p: p0, g: g0, praw: p0, cin: c_eff, valid: in_valid};
  for (genvar k = 1; k <= LEVELS; k++) begin : g_lvl
    localparam int D = 1 << (k - 1);
    logic [WIDTH-1:0] gk, pk;
    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      if (i >= D) begin : g_dot
        pg_dot u_dot (
          .gh(st[k-1].g[i]),
          .ph(st[k-1].p[i]),
          .gl(st[k-1].g[i-D]),
          .pl(st[k-1].p[i-D]),
          .g (gk[i]),
          .p (pk[i])
        );
      end else begin : g_pass
        assign gk[i] = st[k-1].g[i];
        assign pk[i] = st[k-1].p[i];
      end
    end
    assign nx[k] = '{p: pk, g: gk, praw: st[k-1].praw, cin: st[k-1].cin, valid: st[k-1].valid};
  end
  assign carry = {st[LEVELS].g[WIDTH-2:0], st[LEVELS].cin};
  // stage registers plus registered sum/cout/ovf, all advancing together
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int j = 0; j <= LEVELS; j++) st[j] <= '0;
      out_valid <= 1'b0;
      sum       <= '0;
      cout      <= 1'b0;
      ovf       <= 1'b0;
    end else if (en) begin
      for (int j = 0; j <= LEVELS; j++) st[j] <= nx[j];
      out_valid <= st[LEVELS].valid;
      sum       <= st[LEVELS].praw ^ carry;
      cout      <= st[LEVELS].g[WIDTH-1];
      ovf       <= carry[WIDTH-1] ^ st[LEVELS].g[WIDTH-1];
    end
  end
endmodule

// File: doc/pg_prefix_adder_pipe.md
Name: pg_prefix_adder_pipe

Overview:
- Pipelined Kogge-Stone carry-lookahead adder for the MDCLCG datapath.
- Sits directly downstream of the per-bit propagate/generate stage: forms Pi = a^b and Gi = a&b per bit, combines them through log2(WIDTH) registered prefix levels, and emits sum, carry-out and signed overflow.
- Feeds the LCG state-update register with a valid/ready handshake on both sides.

Parameters:
- WIDTH, 32, operand width; power of two, 8..64.
- LEVELS, $clog2(WIDTH), number of prefix levels; derived, not to be overridden.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  operands valid.
- in_ready  out  1  block accepts operands this cycle.
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- cin  in  1  carry-in.
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- sum  out  WIDTH  (a+b+cin) mod 2^WIDTH.
- cout  out  1  carry out of bit WIDTH-1.
- ovf  out  1  signed overflow = carry into MSB ^ cout.

Behaviour:
- Reset (async assert, sync deassert by flops): all stage valid bits 0; sum, cout, ovf, out_valid = 0. in_ready = 1 during and after reset.
- Stage 0 (S0):
  - Registers P = a^b, G = a&b, latches cin.
  - Folds carry-in into bit 0: G0' = G0 | (P0 & cin).
  - Also keeps the raw P vector for the sum.
- Stages S1..S(LEVELS), prefix level k (distance d = 2^(k-1)):
  - For i >= d: G[i] = Gh | (Ph & Gl), P[i] = Ph & Pl, where h = i and l = i-d.
  - For i < d: pass through unchanged.
  - Raw P and cin travel alongside in every stage.
- Output stage:
  - c0 = cin, ci = Gprefix[i-1].
  - sum_i = Praw_i ^ ci; cout = Gprefix[WIDTH-1]; ovf = c(WIDTH-1) ^ cout.
  - All three registered.
- Latency: LEVELS+2 cycles from the accepting edge to out_valid. WIDTH=32 gives 7. Throughput is one result per cycle.
- Handshake:
  - stall = out_valid & ~out_ready.
  - in_ready = ~stall, combinational.
  - Transfer occurs when in_valid & in_ready.
  - On stall, every stage holds data and valid (global enable).
  - Otherwise all stages shift. Bubbles shift as valid=0 and their data is don't-care.
- Outputs are held stable while out_valid=1 and out_ready=0.
- in_valid=0 with in_ready=1: a bubble enters S0.
- Simultaneous output accept and input accept is legal every cycle.
- Reset mid-operation: in-flight results are discarded, with no partial output.
- Wrap-around: carry beyond WIDTH appears only on cout; sum is modulo 2^WIDTH.

Optional Feature:
- Macro PG_ADDER_SUB_EN.
- Defined:
  - Adds input port sub (1 bit), sampled with a and b.
  - Stage 0 uses b_eff = b ^ {WIDTH{sub}} and cin_eff = cin ^ sub.
  - sub=1, cin=0 gives a-b; cout=1 means no borrow.
- Undefined: port sub is absent and behaviour is add-only. Latency is identical in both builds.

Decomposition:
- Package pg_adder_pkg holds:
  - Default WIDTH constant.
  - Function levels_of(width).
  - Packed struct pg_stage_t {P, G, Praw (each WIDTH), cin, valid}.
- One sub-module, pg_dot: 1-bit prefix cell (Gh, Ph, Gl, Pl -> G, P). Instantiated per bit per level via generate.

Test Plan:
- Reset with traffic in flight: drive a valid beat, assert rst_n=0 at cycle 3 -> out_valid=0, sum=0 immediately; no result emerges after release.
- Single add, WIDTH=32: a=0x0000_0001, b=0xFFFF_FFFF, cin=0 -> 7 cycles later sum=0, cout=1, ovf=0, out_valid=1 for exactly one cycle.
- Signed overflow: a=0x7FFF_FFFF, b=0x0000_0001, cin=0 -> sum=0x8000_0000, cout=0, ovf=1; with cin=1 and a=b=0 -> sum=1.
- Streaming plus backpressure:
  - 20 random back-to-back beats; out_ready low for cycles 10-13.
  - in_ready low exactly while the stall holds; outputs held stable.
  - All 20 results in order and matching the reference model.
- Bubbles: in_valid toggling 1,0,1,1,0 -> out_valid pattern 1,0,1,1,0 delayed by 7 cycles.
- With PG_ADDER_SUB_EN: a=5, b=7, sub=1, cin=0 -> sum=0xFFFF_FFFE, cout=0; a=7, b=5 -> sum=2, cout=1.
